// File: rtl/fft_frame_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_buffer_pkg
// Brief    : Shared FFT parameters. The FFT core and its frame buffer both
//            take their frame size and sample width from here.
// Revision : 1.0 - initial release
// ============================================================================
package fft_frame_buffer_pkg;

    // log2 of the FFT frame length (16 bins)
    localparam int c_FFT_LGSIZE = 4;

    // Bits per real / imaginary component of an FFT output sample
    localparam int c_FFT_WIDTH  = 19;

endpackage
`default_nettype wire

// File: rtl/fft_bank_ram.sv
`default_nettype none
// ============================================================================
// Module   : fft_bank_ram
// Brief    : Simple dual-port sample store for two frame banks. The bank
//            select is the address MSB. The read port is registered and holds
//            its output while i_re is low.
// Revision : 1.0 - initial release
// ============================================================================
module fft_bank_ram
    import fft_frame_buffer_pkg::*;
#(
    parameter int AW = c_FFT_LGSIZE + 1,
    parameter int DW = 2 * c_FFT_WIDTH
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_rdata;

    // Write port
    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    // Registered read port. It holds while the consumer stalls.
    always_ff @(posedge i_clk) begin
        if (i_re)
            r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/fft_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_buffer
// Brief    : Two-bank ping-pong buffer between an FFT core and a ready/valid
//            consumer. Whole frames are collected, then replayed in order
//            from bin 0 to bin N-1. A frame is dropped whole when no bank
//            is free at its bin 0.
// Revision : 1.0 - initial release
// ============================================================================
module fft_frame_buffer
    import fft_frame_buffer_pkg::*;
#(
    parameter int LGSIZE = c_FFT_LGSIZE,
    parameter int WIDTH  = c_FFT_WIDTH
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_ce,
    input  logic                i_sync,
    input  logic [2*WIDTH-1:0]  i_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [2*WIDTH-1:0]  o_data,
    output logic [LGSIZE-1:0]   o_bin,
    output logic                o_last,
    output logic                o_dropped
);

    localparam logic [LGSIZE-1:0] c_LAST_BIN = '1;
    localparam logic [LGSIZE-1:0] c_BIN_ONE  = LGSIZE'(1);

    // Per-bank state. r_full_d is r_full delayed one cycle. It adds one
    // cycle before the reader can start on a newly filled bank.
    logic [1:0]         r_full;
    logic [1:0]         r_full_d;

    // Writer state
    logic               r_wr_active;
    logic               r_wr_drop;
    logic               r_wr_bank;
    logic [LGSIZE-1:0]  r_wr_bin;
    logic               r_dropped;

    // Reader state. r_bank/r_bin describe the sample on o_data.
    // r_rd_bank is the next bank to start.
    logic               r_valid;
    logic               r_bank;
    logic [LGSIZE-1:0]  r_bin;
    logic               r_rd_bank;

    logic               w_xfer;
    logic [1:0]         w_clear;
    logic [1:0]         w_set;
    logic [1:0]         w_free;
    logic               w_bin0;
    logic               w_bank_ok;
    logic               w_we;
    logic [LGSIZE-1:0]  w_wbin;
    logic               w_adv;
    logic               w_more;
    logic               w_avail;
    logic               w_nxt_bank;
    logic [LGSIZE-1:0]  w_nxt_bin;
    logic [2*WIDTH-1:0] w_rdata;

    assign w_xfer    = r_valid && i_ready;
    assign w_free    = ~r_full | w_clear;
    // Bin 0 is either an explicit sync or the sample after a wrap.
    assign w_bin0    = i_ce && (i_sync || (r_wr_active && (r_wr_bin == '0)));
    assign w_bank_ok = w_free[r_wr_bank];
    assign w_we      = w_bin0 ? w_bank_ok : (i_ce && r_wr_active && !r_wr_drop);
    assign w_wbin    = w_bin0 ? '0 : r_wr_bin;
    assign w_adv     = !r_valid || i_ready;

    // A bank is freed by the transfer of its last bin. A bank is set full
    // when its last bin is written.
    always_comb begin
        w_clear = 2'b00;
        w_set   = 2'b00;
        if (w_xfer && (r_bin == c_LAST_BIN))
            w_clear[r_bank] = 1'b1;
        if (w_we && (w_wbin == c_LAST_BIN))
            w_set[r_wr_bank] = 1'b1;
    end

    // Pick the next sample to fetch: the next bin of this bank, or bin 0
    // of the next bank once that bank has been full for a cycle.
    always_comb begin
        w_more     = r_valid && (r_bin != c_LAST_BIN);
        w_nxt_bank = r_rd_bank;
        w_nxt_bin  = '0;
        w_avail    = r_full[r_rd_bank] && r_full_d[r_rd_bank];
        if (w_more) begin
            w_nxt_bank = r_bank;
            w_nxt_bin  = r_bin + 1'b1;
            w_avail    = 1'b1;
        end
    end

    // Bank full flags and their one-cycle-delayed copies
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_full   <= 2'b00;
            r_full_d <= 2'b00;
        end else begin
            r_full   <= (r_full & ~w_clear) | w_set;
            r_full_d <= r_full & ~w_clear;
        end
    end

    // Writer: sync acquisition, bin counting, bank switching and frame discard
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_active <= 1'b0;
            r_wr_drop   <= 1'b0;
            r_wr_bank   <= 1'b0;
            r_wr_bin    <= '0;
            r_dropped   <= 1'b0;
        end else begin
            r_dropped <= w_bin0 && !w_bank_ok;
            if (w_bin0) begin
                r_wr_active <= 1'b1;
                r_wr_drop   <= !w_bank_ok;
                r_wr_bin    <= c_BIN_ONE;
            end else if (i_ce && r_wr_active) begin
                if (r_wr_bin == c_LAST_BIN) begin
                    r_wr_bin  <= '0;
                    r_wr_drop <= 1'b0;
                    if (!r_wr_drop)
                        r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_bin <= r_wr_bin + 1'b1;
                end
            end
        end
    end

    // Reader: load the output stage whenever it is empty or being consumed
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_valid   <= 1'b0;
            r_bank    <= 1'b0;
            r_bin     <= '0;
            r_rd_bank <= 1'b0;
        end else if (w_adv) begin
            r_valid <= w_avail;
            if (w_avail) begin
                r_bank <= w_nxt_bank;
                r_bin  <= w_nxt_bin;
                if (!w_more)
                    r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    fft_bank_ram #(
        .AW (LGSIZE + 1),
        .DW (2 * WIDTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr ({r_wr_bank, w_wbin}),
        .i_wdata (i_data),
        .i_re    (w_adv && w_avail),
        .i_raddr ({w_nxt_bank, w_nxt_bin}),
        .o_rdata (w_rdata)
    );

    // The RAM output register is not reset, so it is masked while idle.
    assign o_valid   = r_valid;
    assign o_data    = r_valid ? w_rdata : '0;
    assign o_bin     = r_bin;
    assign o_last    = r_valid && (r_bin == c_LAST_BIN);
    assign o_dropped = r_dropped;

endmodule
`default_nettype wire
